// File: rtl/id_ex_stage_pkg.sv
// Shared types for the ID/EX stage: widths, ALU opcodes, EX register bundle.
// Latency: n/a (types only).
// Backpressure: n/a.
package id_ex_stage_pkg;

    localparam int CPU_WIDTH = 32;
    localparam int DATA_W    = CPU_WIDTH;
    localparam int REG_AW    = 5;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [REG_AW-1:0] reg_addr_t;

    typedef enum logic [2:0] {
        ADD_op = 3'd0,
        SUB_op = 3'd1,
        AND_op = 3'd2,
        OR_op  = 3'd3,
        XOR_op = 3'd4,
        SLT_op = 3'd5,
        SLL_op = 3'd6,
        SRL_op = 3'd7
    } alu_op_t;

    typedef struct packed {
        logic      valid;
        data_t     pc;
        reg_addr_t rs1_addr;
        reg_addr_t rs2_addr;
        data_t     rs1_val;
        data_t     rs2_val;
        data_t     imm;
        logic      use_imm;
        alu_op_t   aluop;
        reg_addr_t rd_addr;
        logic      rd_we;
        logic      is_load;
    } ex_regs_t;

    function automatic ex_regs_t ex_bubble();
        ex_regs_t b;
        b       = '0;
        b.aluop = ADD_op;
        return b;
    endfunction

    // A writer with a nonzero destination that matches either ID source.
    function automatic logic src_conflict(reg_addr_t rd, logic we, reg_addr_t rs1, reg_addr_t rs2);
        return we && (rd != '0) && ((rd == rs1) || (rd == rs2));
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle between decode/downstream stages and the ID/EX stage.
// Latency: n/a (wiring only).
// Backpressure: stall/flush from the controller; hazard_stall back to it.
interface id_ex_stage_if;
    import id_ex_stage_pkg::*;

    logic      stall;
    logic      flush;
    logic      id_valid;
    data_t     id_pc;
    reg_addr_t id_rs1_addr;
    reg_addr_t id_rs2_addr;
    data_t     id_rs1_val;
    data_t     id_rs2_val;
    data_t     id_imm;
    logic      id_use_imm;
    alu_op_t   id_aluop;
    reg_addr_t id_rd_addr;
    logic      id_rd_we;
    logic      id_is_load;

    reg_addr_t exmem_rd_addr;
    reg_addr_t memwb_rd_addr;
    logic      exmem_rd_we;
    logic      memwb_rd_we;
    data_t     exmem_result;
    data_t     memwb_result;

    data_t     alu_a;
    data_t     alu_b;
    alu_op_t   alu_op;
    logic      ex_valid;
    data_t     ex_pc;
    reg_addr_t ex_rd_addr;
    logic      ex_rd_we;
    logic      ex_is_load;
    data_t     ex_store_data;
    logic      hazard_stall;

    modport master (
        output stall, flush, id_valid, id_pc, id_rs1_addr, id_rs2_addr,
               id_rs1_val, id_rs2_val, id_imm, id_use_imm, id_aluop,
               id_rd_addr, id_rd_we, id_is_load,
               exmem_rd_addr, memwb_rd_addr, exmem_rd_we, memwb_rd_we,
               exmem_result, memwb_result,
        input  alu_a, alu_b, alu_op, ex_valid, ex_pc, ex_rd_addr, ex_rd_we,
               ex_is_load, ex_store_data, hazard_stall
    );

    modport slave (
        input  stall, flush, id_valid, id_pc, id_rs1_addr, id_rs2_addr,
               id_rs1_val, id_rs2_val, id_imm, id_use_imm, id_aluop,
               id_rd_addr, id_rd_we, id_is_load,
               exmem_rd_addr, memwb_rd_addr, exmem_rd_we, memwb_rd_we,
               exmem_result, memwb_result,
        output alu_a, alu_b, alu_op, ex_valid, ex_pc, ex_rd_addr, ex_rd_we,
               ex_is_load, ex_store_data, hazard_stall
    );

endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding mux: EX/MEM over MEM/WB over register value; x0 never forwarded.
// Latency: combinational.
// Backpressure: none.
module id_ex_stage_fwd_mux
    import id_ex_stage_pkg::*;
(
    input  reg_addr_t rs_addr_i,
    input  data_t     reg_val_i,
    input  reg_addr_t exmem_rd_addr_i,
    input  logic      exmem_rd_we_i,
    input  data_t     exmem_result_i,
    input  reg_addr_t memwb_rd_addr_i,
    input  logic      memwb_rd_we_i,
    input  data_t     memwb_result_i,
    output data_t     fwd_val_o
);

    always_comb begin
        fwd_val_o = reg_val_i;
        if (rs_addr_i != '0) begin
            if (exmem_rd_we_i && (exmem_rd_addr_i == rs_addr_i)) begin
                fwd_val_o = exmem_result_i;
            end else if (memwb_rd_we_i && (memwb_rd_addr_i == rs_addr_i)) begin
                fwd_val_o = memwb_result_i;
            end
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with RAW forwarding and hazard request (FORWARD_EN enables forwarding).
// Latency: 1 cycle id_* -> ex_*; ALU operands combinational from downstream results.
// Backpressure: flush > stall > load; hazard_stall asks the controller to stall IF/ID and flush here.
module id_ex_stage
    import id_ex_stage_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    id_ex_stage_if.slave   bus
);

`ifdef FORWARD_EN
    localparam logic FWD_ON = 1'b1;
`else
    localparam logic FWD_ON = 1'b0;
`endif

    ex_regs_t ex_q;
    ex_regs_t ex_d;
    ex_regs_t id_fields;
    data_t    rs1_fwd;
    data_t    rs2_fwd;
    logic     load_use;
    logic     raw_any;

    always_comb begin
        id_fields          = ex_bubble();
        id_fields.valid    = bus.id_valid;
        id_fields.pc       = bus.id_pc;
        id_fields.rs1_addr = bus.id_rs1_addr;
        id_fields.rs2_addr = bus.id_rs2_addr;
        id_fields.rs1_val  = bus.id_rs1_val;
        id_fields.rs2_val  = bus.id_rs2_val;
        id_fields.imm      = bus.id_imm;
        id_fields.use_imm  = bus.id_use_imm;
        id_fields.aluop    = bus.id_aluop;
        id_fields.rd_addr  = bus.id_rd_addr;
        id_fields.rd_we    = bus.id_rd_we & bus.id_valid;
        id_fields.is_load  = bus.id_is_load;
    end

    always_comb begin
        ex_d = ex_q;
        if (bus.flush) begin
            ex_d = ex_bubble();
        end else if (!bus.stall) begin
            ex_d = id_fields;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= ex_bubble();
        end else begin
            ex_q <= ex_d;
        end
    end

    // With forwarding disabled the write enables are masked, so the muxes pass the register value.
    id_ex_stage_fwd_mux u_fwd_rs1 (
        .rs_addr_i       (ex_q.rs1_addr),
        .reg_val_i       (ex_q.rs1_val),
        .exmem_rd_addr_i (bus.exmem_rd_addr),
        .exmem_rd_we_i   (bus.exmem_rd_we & FWD_ON),
        .exmem_result_i  (bus.exmem_result),
        .memwb_rd_addr_i (bus.memwb_rd_addr),
        .memwb_rd_we_i   (bus.memwb_rd_we & FWD_ON),
        .memwb_result_i  (bus.memwb_result),
        .fwd_val_o       (rs1_fwd)
    );

    id_ex_stage_fwd_mux u_fwd_rs2 (
        .rs_addr_i       (ex_q.rs2_addr),
        .reg_val_i       (ex_q.rs2_val),
        .exmem_rd_addr_i (bus.exmem_rd_addr),
        .exmem_rd_we_i   (bus.exmem_rd_we & FWD_ON),
        .exmem_result_i  (bus.exmem_result),
        .memwb_rd_addr_i (bus.memwb_rd_addr),
        .memwb_rd_we_i   (bus.memwb_rd_we & FWD_ON),
        .memwb_result_i  (bus.memwb_result),
        .fwd_val_o       (rs2_fwd)
    );

    assign load_use = bus.id_valid &&
                      src_conflict(ex_q.rd_addr, ex_q.valid & ex_q.is_load,
                                   bus.id_rs1_addr, bus.id_rs2_addr);

`ifdef FORWARD_EN
    assign raw_any = 1'b0;
`else
    // Without bypass paths every in-flight producer must drain before ID may read.
    assign raw_any = bus.id_valid &&
                     (src_conflict(ex_q.rd_addr, ex_q.rd_we,
                                   bus.id_rs1_addr, bus.id_rs2_addr) ||
                      src_conflict(bus.exmem_rd_addr, bus.exmem_rd_we,
                                   bus.id_rs1_addr, bus.id_rs2_addr));
`endif

    assign bus.hazard_stall  = load_use | raw_any;
    assign bus.alu_a         = rs1_fwd;
    assign bus.alu_b         = ex_q.use_imm ? ex_q.imm : rs2_fwd;
    assign bus.ex_store_data = rs2_fwd;
    assign bus.alu_op        = ex_q.aluop;
    assign bus.ex_valid      = ex_q.valid;
    assign bus.ex_pc         = ex_q.pc;
    assign bus.ex_rd_addr    = ex_q.rd_addr;
    assign bus.ex_rd_we      = ex_q.rd_we;
    assign bus.ex_is_load    = ex_q.is_load;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed steps plus randomized traffic against an instruction-level model.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    typedef struct {
        bit          valid;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        bit          use_imm;
        logic [2:0]  op;
        logic [4:0]  rd;
        bit          rd_we;
        bit          is_load;
    } slot_t;

    logic  clk   = 1'b0;
    logic  rst_n = 1'b0;
    int    checks = 0;
    int    errors = 0;
    slot_t ex_m;

    id_ex_stage_if bus();

    id_ex_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic slot_t empty_slot();
        slot_t s;
        s.valid = 0; s.pc = 0; s.rs1 = 0; s.rs2 = 0; s.rs1_val = 0; s.rs2_val = 0;
        s.imm = 0; s.use_imm = 0; s.op = 3'd0; s.rd = 0; s.rd_we = 0; s.is_load = 0;
        return s;
    endfunction

    // Value a source operand should see given the current downstream writers.
    function automatic logic [31:0] fwd(logic [4:0] rs, logic [31:0] regv);
`ifdef FORWARD_EN
        if (rs != 0) begin
            if (bus.exmem_rd_we && bus.exmem_rd_addr == rs) return bus.exmem_result;
            if (bus.memwb_rd_we && bus.memwb_rd_addr == rs) return bus.memwb_result;
        end
`endif
        return regv;
    endfunction

    function automatic logic hz();
        logic [4:0] srcs [2];
        bit hit = 0;
        srcs[0] = bus.id_rs1_addr;
        srcs[1] = bus.id_rs2_addr;
        if (!bus.id_valid) return 1'b0;
        foreach (srcs[k]) begin
            if (ex_m.valid && ex_m.is_load && ex_m.rd != 0 && ex_m.rd == srcs[k]) hit = 1;
`ifndef FORWARD_EN
            if (ex_m.rd_we && ex_m.rd != 0 && ex_m.rd == srcs[k]) hit = 1;
            if (bus.exmem_rd_we && bus.exmem_rd_addr != 0 && bus.exmem_rd_addr == srcs[k]) hit = 1;
`endif
        end
        return hit;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ".alu_a"}, bus.alu_a, fwd(ex_m.rs1, ex_m.rs1_val));
        chk({ctx, ".alu_b"}, bus.alu_b, ex_m.use_imm ? ex_m.imm : fwd(ex_m.rs2, ex_m.rs2_val));
        chk({ctx, ".store"}, bus.ex_store_data, fwd(ex_m.rs2, ex_m.rs2_val));
        chk({ctx, ".alu_op"}, 32'(bus.alu_op), 32'(ex_m.op));
        chk({ctx, ".ex_valid"}, 32'(bus.ex_valid), 32'(ex_m.valid));
        chk({ctx, ".ex_pc"}, bus.ex_pc, ex_m.pc);
        chk({ctx, ".ex_rd_addr"}, 32'(bus.ex_rd_addr), 32'(ex_m.rd));
        chk({ctx, ".ex_rd_we"}, 32'(bus.ex_rd_we), 32'(ex_m.rd_we));
        chk({ctx, ".ex_is_load"}, 32'(bus.ex_is_load), 32'(ex_m.is_load));
        chk({ctx, ".hazard"}, 32'(bus.hazard_stall), 32'(hz()));
    endtask

    // One clock: model applies flush > stall > load at the edge, then settle.
    task automatic tick();
        slot_t nxt;
        nxt = ex_m;
        if (bus.flush) begin
            nxt = empty_slot();
        end else if (!bus.stall) begin
            nxt.valid = bus.id_valid;       nxt.pc = bus.id_pc;
            nxt.rs1 = bus.id_rs1_addr;      nxt.rs2 = bus.id_rs2_addr;
            nxt.rs1_val = bus.id_rs1_val;   nxt.rs2_val = bus.id_rs2_val;
            nxt.imm = bus.id_imm;           nxt.use_imm = bus.id_use_imm;
            nxt.op = bus.id_aluop;          nxt.rd = bus.id_rd_addr;
            nxt.rd_we = bus.id_rd_we & bus.id_valid;
            nxt.is_load = bus.id_is_load;
        end
        @(posedge clk);
        ex_m = rst_n ? nxt : empty_slot();
        #1;
    endtask

    task automatic set_id(input bit v, input logic [31:0] pc,
                          input logic [4:0] r1, input logic [31:0] v1,
                          input logic [4:0] r2, input logic [31:0] v2,
                          input logic [31:0] imm, input bit ui, input logic [2:0] op,
                          input logic [4:0] rd, input bit we, input bit ld);
        bus.id_valid = v;     bus.id_pc = pc;
        bus.id_rs1_addr = r1; bus.id_rs1_val = v1;
        bus.id_rs2_addr = r2; bus.id_rs2_val = v2;
        bus.id_imm = imm;     bus.id_use_imm = ui;
        bus.id_aluop = alu_op_t'(op);
        bus.id_rd_addr = rd;  bus.id_rd_we = we; bus.id_is_load = ld;
    endtask

    task automatic set_down(input logic [4:0] ea, input bit ew, input logic [31:0] er,
                            input logic [4:0] ma, input bit mw, input logic [31:0] mr);
        bus.exmem_rd_addr = ea; bus.exmem_rd_we = ew; bus.exmem_result = er;
        bus.memwb_rd_addr = ma; bus.memwb_rd_we = mw; bus.memwb_result = mr;
    endtask

    initial begin
        ex_m = empty_slot();
        bus.stall = 0;
        bus.flush = 0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0);
        set_down(0, 0, 0, 0, 0, 0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        chk("reset.ex_valid", 32'(bus.ex_valid), 32'd0);
        rst_n = 1'b1;

        // Plain ADD: rs1=x5 (10), rs2=x6 (3)
        set_id(1, 32'h100, 5, 32'd10, 6, 32'd3, 32'h0, 0, 3'd0, 8, 1, 0);
        tick();
        check_all("add");
        chk("add.alu_a_lit", bus.alu_a, 32'd10);
        chk("add.alu_b_lit", bus.alu_b, 32'd3);

        // Asynchronous reset between edges
        set_id(1, 32'h104, 1, 32'h77, 2, 32'h66, 32'h0, 0, 3'd3, 9, 1, 1);
        tick();
        #2 rst_n = 1'b0;
        #1;
        ex_m = empty_slot();
        chk("arst.ex_valid", 32'(bus.ex_valid), 32'd0);
        chk("arst.alu_a", bus.alu_a, 32'd0);
        chk("arst.alu_b", bus.alu_b, 32'd0);
        chk("arst.alu_op", 32'(bus.alu_op), 32'(ADD_op));
        #1 rst_n = 1'b1;
        set_id(1, 32'h100, 5, 32'd10, 6, 32'd3, 32'h0, 0, 3'd0, 8, 1, 0);
        tick();
        check_all("reload");
        chk("reload.alu_a_lit", bus.alu_a, 32'd10);
        chk("reload.alu_b_lit", bus.alu_b, 32'd3);

        // Forwarding priority on rs1=x7
        set_id(1, 32'h200, 7, 32'd1, 9, 32'd2, 32'h0, 0, 3'd1, 11, 1, 0);
        tick();
        bus.id_valid = 0;
        set_down(7, 1, 32'h55, 7, 1, 32'h99);
        #1;
        check_all("fwd_both");
`ifdef FORWARD_EN
        chk("fwd_both.alu_a_lit", bus.alu_a, 32'h55);
`else
        chk("fwd_both.alu_a_lit", bus.alu_a, 32'd1);
`endif
        bus.exmem_rd_we = 0;
        #1;
        check_all("fwd_memwb");
`ifdef FORWARD_EN
        chk("fwd_memwb.alu_a_lit", bus.alu_a, 32'h99);
`else
        chk("fwd_memwb.alu_a_lit", bus.alu_a, 32'd1);
`endif

        // x0 is never forwarded
        set_down(0, 0, 0, 0, 0, 0);
        set_id(1, 32'h204, 0, 32'd0, 0, 32'd0, 32'h0, 0, 3'd0, 12, 1, 0);
        tick();
        set_down(0, 1, 32'hFFFF, 0, 1, 32'h1234);
        #1;
        check_all("x0");
        chk("x0.alu_a_lit", bus.alu_a, 32'd0);
        set_down(0, 0, 0, 0, 0, 0);

        // Load-use hazard
        set_id(1, 32'h300, 1, 32'h0, 2, 32'h0, 32'h8, 1, 3'd0, 3, 1, 1);
        tick();
        set_id(1, 32'h304, 4, 32'h0, 3, 32'h0, 32'h0, 0, 3'd0, 13, 1, 0);
        #1;
        check_all("lu_hit");
        chk("lu_hit.lit", 32'(bus.hazard_stall), 32'd1);
        set_id(1, 32'h300, 1, 32'h0, 2, 32'h0, 32'h8, 1, 3'd0, 0, 1, 1);
        tick();
        set_id(1, 32'h304, 4, 32'h0, 0, 32'h0, 32'h0, 0, 3'd0, 13, 1, 0);
        #1;
        check_all("lu_rd0");
        chk("lu_rd0.lit", 32'(bus.hazard_stall), 32'd0);
        set_id(0, 32'h300, 1, 32'h0, 2, 32'h0, 32'h8, 1, 3'd0, 3, 1, 1);
        tick();
        set_id(1, 32'h304, 4, 32'h0, 3, 32'h0, 32'h0, 0, 3'd0, 13, 1, 0);
        #1;
        check_all("lu_inv");
        chk("lu_inv.lit", 32'(bus.hazard_stall), 32'd0);

        // Stall holds, flush beats stall
        set_id(1, 32'h400, 1, 32'h5, 2, 32'h6, 32'h0, 0, 3'd2, 14, 1, 0);
        tick();
        bus.stall = 1;
        for (int i = 0; i < 3; i++) begin
            set_id(1, 32'h500 + 32'(i * 4), 3, 32'h7, 4, 32'h8, 32'h0, 1, 3'd4, 15, 1, 1);
            tick();
            check_all("stall");
            chk("stall.ex_pc_lit", bus.ex_pc, 32'h400);
        end
        bus.flush = 1;
        tick();
        check_all("stall_flush");
        chk("stall_flush.ex_valid", 32'(bus.ex_valid), 32'd0);
        chk("stall_flush.ex_rd_we", 32'(bus.ex_rd_we), 32'd0);
        bus.stall = 0;
        bus.flush = 0;

        // Immediate selects operand B, store data still forwarded rs2
        set_id(1, 32'h600, 1, 32'h1, 10, 32'h7, 32'hFFFF_FFFC, 1, 3'd0, 16, 1, 0);
        tick();
        bus.id_valid = 0;
        set_down(10, 1, 32'h12, 0, 0, 0);
        #1;
        check_all("imm");
        chk("imm.alu_b_lit", bus.alu_b, 32'hFFFF_FFFC);
`ifdef FORWARD_EN
        chk("imm.store_lit", bus.ex_store_data, 32'h12);
`else
        chk("imm.store_lit", bus.ex_store_data, 32'h7);
`endif

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            bus.stall = ($urandom_range(0, 3) == 0);
            bus.flush = ($urandom_range(0, 7) == 0);
            set_id(1'($urandom_range(0, 1)), $urandom,
                   5'($urandom_range(0, 7)), $urandom,
                   5'($urandom_range(0, 7)), $urandom,
                   $urandom, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            set_down(5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom,
                     5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom);
            #1;
            check_all("rand");
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage that sits directly upstream of the ALU. It latches decoded operands and control from the decode stage and applies stall and flush control. It resolves RAW hazards by forwarding from EX/MEM and MEM/WB, and it raises a load-use stall request. Its outputs drive the ALU operand and opcode inputs and carry destination/PC information forward to EX/MEM.

## Interface
- DATA_W, 32, datapath width (equals `CPU_WIDTH`)
- REG_AW, 5, register address width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  hold current contents
- flush  in  1  replace contents with bubble (branch/interrupt)
- id_valid  in  1  decode stage holds a real instruction
- id_pc  in  DATA_W  instruction PC
- id_rs1_addr, id_rs2_addr  in  REG_AW  source registers
- id_rs1_val, id_rs2_val  in  DATA_W  register-file read data
- id_imm  in  DATA_W  sign-extended immediate
- id_use_imm  in  1  operand B selects immediate
- id_aluop  in  3  ALU opcode (`ADD_op`…`SRL_op`)
- id_rd_addr  in  REG_AW  destination
- id_rd_we  in  1  writes destination
- id_is_load  in  1  instruction is a load
- exmem_rd_addr, memwb_rd_addr  in  REG_AW  downstream destinations
- exmem_rd_we, memwb_rd_we  in  1  downstream write enables
- exmem_result, memwb_result  in  DATA_W  downstream results
- alu_a, alu_b  out  DATA_W  ALU operands
- alu_op  out  3  ALU opcode
- ex_valid  out  1  EX holds a real instruction
- ex_pc  out  DATA_W  PC of EX instruction
- ex_rd_addr  out  REG_AW; ex_rd_we  out  1; ex_is_load  out  1
- ex_store_data  out  DATA_W  forwarded rs2 value
- hazard_stall  out  1  request that IF/ID stall and this stage flush

## Operation
- Register update on each clk rising edge. Priority: flush > stall > load.
- Load: all id_* fields are captured. ex_valid is set to id_valid. ex_rd_we is set to id_rd_we & id_valid.
- Stall: all registers hold their values.
- Flush, or reset, produces a bubble: ex_valid=0, ex_rd_we=0, ex_is_load=0, alu_op=`ADD_op`, and every data/address register is 0.
- Forwarding is combinational from the registered rs addresses. The rs1 and rs2 paths are forwarded independently.
  - Source 1: EX/MEM when exmem_rd_we and exmem_rd_addr == rs and rs != 0.
  - Source 2: MEM/WB when memwb_rd_we and memwb_rd_addr == rs and rs != 0.
  - Otherwise: the registered value.
  - EX/MEM has priority over MEM/WB.
- alu_a is the forwarded rs1 value.
- alu_b is the registered immediate if use_imm is set, otherwise the forwarded rs2 value.
- ex_store_data is always the forwarded rs2 value.
- hazard_stall is combinational. It is 1 when all of the following hold:
  - ex_valid, ex_is_load and ex_rd_addr != 0;
  - id_valid;
  - ex_rd_addr == id_rs1_addr, or ex_rd_addr == id_rs2_addr.
- hazard_stall is not gated by id_use_imm (conservative).
- The upstream controller converts hazard_stall into stall of IF/ID plus flush of this stage. This block does not self-flush.
- Register x0 is never a forwarding source, even if a downstream stage reports a write to x0.

## Timing
- Latency: one cycle from id_* to the registered ex_* fields.
- alu_a, alu_b and ex_store_data are valid in the same cycle as the exmem/memwb inputs. The path is purely combinational, with no added latency.
- Reset is asynchronous assert and synchronous-safe deassert at the flop level. Every register takes its bubble value immediately.
- Reset mid-operation discards the in-flight instruction. There is no replay.
- flush and stall in the same cycle: flush wins.
- A stall held for N cycles keeps the outputs constant. The forwarded values may still change while stalled, because downstream stages keep advancing.
- The register file is write-first. MEM/WB forwarding therefore covers only the case where the register-file read happened before the writeback.

## Configuration
- FORWARD_EN defined:
  - Forwarding muxes present.
  - hazard_stall covers load-use only, as above.
- FORWARD_EN undefined:
  - alu_a and ex_store_data use the registered values only. alu_b uses the registered rs2 value when id_use_imm is clear. The exmem/memwb result ports are unused.
  - hazard_stall is extended to any RAW conflict: ID's rs1 or rs2 matches a nonzero ex_rd_addr with ex_rd_we, or a nonzero exmem_rd_addr with exmem_rd_we.

## Structure
- ALU opcode encodings and width macros come from the shared para.v (`DATABUS`, `CPU_WIDTH`, `ADD_op`…).
- Add `REGBUS` / `REG_AW` there if absent.
- One natural sub-module: fwd_mux. It takes rs_addr, reg_val and both downstream triples, and returns the forwarded value. It is instantiated twice, for rs1 and rs2.

## Test plan
- Reset:
  - Drive rst_n=0 mid-stream → ex_valid=0, alu_a=alu_b=0, and alu_op=`ADD_op`, asynchronously.
  - Then load an ADD with rs1=5 (value 10) and rs2=6 (value 3) → next cycle alu_a=10, alu_b=3.
- EX/MEM forwarding priority:
  - EX has rs1=7 (value 1); exmem writes x7=0x55; memwb writes x7=0x99 → alu_a=0x55.
  - Drop exmem_rd_we → alu_a=0x99.
- x0 guard: rs1=0 and exmem writes x0=0xFFFF → alu_a equals the registered value 0.
- Load-use:
  - EX holds a load to x3 while ID reads rs2=x3 → hazard_stall=1.
  - Same case with ex_rd_addr=0, or with ex_valid=0 → hazard_stall=0.
- Stall/flush:
  - stall=1 for 3 cycles with new id_* values → ex_pc held.
  - stall=1 and flush=1 together → bubble (ex_rd_we=0, ex_valid=0).
- Immediate: id_use_imm=1, imm=0xFFFFFFFC and rs2 forwarded as 0x12 → alu_b=0xFFFFFFFC and ex_store_data=0x12.
